// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART frame parser
// Contents:
//   HEADER_DEFAULT   default start-of-frame byte
//   ERR_*            error codes reported on err_code_out
//   parser_state_t   one-hot parser state encoding
package uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [4:0] {
    ST_HUNT    = 5'b00001,
    ST_LEN     = 5'b00010,
    ST_PAYLOAD = 5'b00100,
    ST_CHECK   = 5'b01000,
    ST_DRAIN   = 5'b10000
  } parser_state_t;

endpackage

// File: rtl/frame_buf_ram.sv
// rtl/frame_buf_ram.sv - payload buffer, DEPTH x 8 register file, 1 write / 1 async read port
// Ports:
//   clk       system clock (write port)
//   i_we      write enable
//   i_waddr   write address
//   i_wdata   write data
//   i_raddr   read address
//   o_rdata   read data, combinational from i_raddr
module frame_buf_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  // Index width actually needed to address DEPTH entries; the callers' counters
  // are one bit wider because they must also hold the value DEPTH.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is intentionally not reset; contents are only read after being written.
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[IW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr[IW-1:0]];

  generate
    if (AW > IW) begin : g_addr_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{i_waddr[AW-1:IW], i_raddr[AW-1:IW]};
    end
  endgenerate

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles HEADER/LEN/payload/CHK frames from a UART byte strobe
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_data_in        received byte, qualified by rxOK_in
//   rxOK_in           one-cycle byte strobe
//   m_data_out        payload byte stream (valid/ready)
//   m_valid_out       m_data_out valid
//   m_ready_in        consumer accepts byte
//   m_last_out        final payload byte of the frame
//   frame_len_out     LEN of the frame being drained, held until the next good frame
//   frame_ok_out      pulse: frame passed checksum
//   frame_err_out     pulse: frame discarded
//   err_code_out      01 bad LEN, 10 checksum, 11 timeout; held until the next error
//   drop_out          pulse: byte arrived while draining and was lost
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_in,
  input  logic       rxOK_in,
  output logic [7:0] m_data_out,
  output logic       m_valid_out,
  input  logic       m_ready_in,
  output logic       m_last_out,
  output logic [7:0] frame_len_out,
  output logic       frame_ok_out,
  output logic       frame_err_out,
  output logic [1:0] err_code_out,
  output logic       drop_out
);

  localparam int            AW        = $clog2(MAX_LEN + 1);
  localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_chk;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_rd_idx;
  logic [TW-1:0] r_tmo;

  logic [AW-1:0] w_rd_next;
  logic [AW-1:0] w_raddr;
  logic [7:0]    w_rd_data;
  logic [7:0]    w_idx8;
  logic [7:0]    w_rd_next8;
  logic          w_we;
  logic          w_active;
  logic          w_tmo_fire;

  assign w_rd_next  = r_rd_idx + AW'(1);
  assign w_idx8     = 8'(r_idx);
  assign w_rd_next8 = 8'(w_rd_next);
  assign w_we       = rxOK_in && (r_state == ST_PAYLOAD);
  assign w_active   = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
  // A byte in the terminal-count cycle takes priority over the timeout.
  assign w_tmo_fire = w_active && !rxOK_in && (r_tmo == TMO_LAST);

  // m_data_out is registered, so the read port looks one beat ahead: entry 0
  // while the CHK byte is being judged, then rd_idx+1 while draining.
  assign w_raddr = (r_state == ST_DRAIN) ? w_rd_next : '0;

  frame_buf_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (rx_data_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HUNT;
      r_len         <= '0;
      r_chk         <= '0;
      r_idx         <= '0;
      r_rd_idx      <= '0;
      r_tmo         <= '0;
      m_data_out    <= '0;
      m_valid_out   <= 1'b0;
      m_last_out    <= 1'b0;
      frame_len_out <= '0;
      frame_ok_out  <= 1'b0;
      frame_err_out <= 1'b0;
      err_code_out  <= ERR_NONE;
      drop_out      <= 1'b0;
    end else begin
      frame_ok_out  <= 1'b0;
      frame_err_out <= 1'b0;
      drop_out      <= 1'b0;

      if (rxOK_in || !w_active) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TW'(1);
      end

      if (w_tmo_fire) begin
        frame_err_out <= 1'b1;
        err_code_out  <= ERR_TMO;
        r_tmo         <= '0;
        r_state       <= ST_HUNT;
      end else begin
        case (r_state)
          ST_HUNT: begin
            if (rxOK_in && (rx_data_in == HEADER)) begin
              r_state <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (rxOK_in) begin
              if ((rx_data_in == 8'd0) || (rx_data_in > MAX_LEN_B)) begin
                frame_err_out <= 1'b1;
                err_code_out  <= ERR_LEN;
                r_state       <= ST_HUNT;
              end else begin
                r_len   <= rx_data_in;
                r_chk   <= rx_data_in;
                r_idx   <= '0;
                r_state <= ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (rxOK_in) begin
              r_chk <= r_chk ^ rx_data_in;
              r_idx <= r_idx + AW'(1);
              if (w_idx8 == (r_len - 8'd1)) begin
                r_state <= ST_CHECK;
              end
            end
          end

          ST_CHECK: begin
            if (rxOK_in) begin
              if (rx_data_in == r_chk) begin
                frame_ok_out  <= 1'b1;
                frame_len_out <= r_len;
                r_rd_idx      <= '0;
                m_valid_out   <= 1'b1;
                m_data_out    <= w_rd_data;
                m_last_out    <= (r_len == 8'd1);
                r_state       <= ST_DRAIN;
              end else begin
                frame_err_out <= 1'b1;
                err_code_out  <= ERR_CHK;
                r_state       <= ST_HUNT;
              end
            end
          end

          ST_DRAIN: begin
            // The parser cannot accept a new frame until the buffer is empty.
            if (rxOK_in) begin
              drop_out <= 1'b1;
            end
            if (m_valid_out && m_ready_in) begin
              if (m_last_out) begin
                m_valid_out <= 1'b0;
                m_last_out  <= 1'b0;
                m_data_out  <= '0;
                r_state     <= ST_HUNT;
              end else begin
                r_rd_idx   <= w_rd_next;
                m_data_out <= w_rd_data;
                m_last_out <= (w_rd_next8 == (r_len - 8'd1));
              end
            end
          end

          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int EV_OK   = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DROP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data_in = 8'h00;
  logic       rxOK_in = 1'b0;
  logic [7:0] m_data_out;
  logic       m_valid_out;
  logic       m_ready_in = 1'b1;
  logic       m_last_out;
  logic [7:0] frame_len_out;
  logic       frame_ok_out;
  logic       frame_err_out;
  logic [1:0] err_code_out;
  logic       drop_out;

  uart_frame_parser #(
    .HEADER         (8'hAA),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_in    (rx_data_in),
    .rxOK_in       (rxOK_in),
    .m_data_out    (m_data_out),
    .m_valid_out   (m_valid_out),
    .m_ready_in    (m_ready_in),
    .m_last_out    (m_last_out),
    .frame_len_out (frame_len_out),
    .frame_ok_out  (frame_ok_out),
    .frame_err_out (frame_err_out),
    .err_code_out  (err_code_out),
    .drop_out      (drop_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic [7:0] len;
  } beat_t;

  typedef struct {
    int         kind;
    logic [1:0] code;
    int         at;
  } evt_t;

  beat_t exp_beats[$];
  evt_t  exp_evts[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take_evt(input int kind, input string name);
    evt_t e;
    if (exp_evts.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got pulse expected none (cycle %0d)", name, cyc);
    end else begin
      e = exp_evts.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (kind == EV_ERR) check("err_code", err_code_out, e.code);
      if (e.at >= 0) check({name, "_cycle"}, cyc, e.at);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst_n) begin
      check("ok_err_exclusive", frame_ok_out & frame_err_out, 0);
      if (m_valid_out) begin
        if (exp_beats.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got data %0h expected no beat (cycle %0d)", m_data_out, cyc);
        end else begin
          b = exp_beats[0];
          check("m_data", m_data_out, b.d);
          check("m_last", m_last_out, b.last);
          check("frame_len", frame_len_out, b.len);
          if (m_ready_in) void'(exp_beats.pop_front());
        end
      end
      if (frame_ok_out) begin
        take_evt(EV_OK, "frame_ok");
        check("valid_with_ok", m_valid_out, 1);
      end
      if (frame_err_out) take_evt(EV_ERR, "frame_err");
      if (drop_out) take_evt(EV_DROP, "drop");
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data_in = b;
    rxOK_in    = 1'b1;
    @(posedge clk);
    #1;
    rxOK_in    = 1'b0;
    rx_data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_evt(input int kind, input logic [1:0] code, input int at);
    evt_t e;
    e.kind = kind;
    e.code = code;
    e.at   = at;
    exp_evts.push_back(e);
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic last, input logic [7:0] len);
    beat_t b;
    b.d    = d;
    b.last = last;
    b.len  = len;
    exp_beats.push_back(b);
  endtask

  function automatic logic [31:0] all_outputs();
    return {9'd0, m_data_out, m_valid_out, m_last_out, frame_len_out,
            frame_ok_out, frame_err_out, err_code_out, drop_out};
  endfunction

  logic [4:0] ready_pat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    idle(2);
    check("idle_outputs", all_outputs(), 0);

    // Good frame, LEN 3: CHK = 03^11^22^33 = 03
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'h11, 1'b0, 8'd3);
    exp_beat(8'h22, 1'b0, 8'd3);
    exp_beat(8'h33, 1'b1, 8'd3);
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle(5);

    // Bad checksum (expected 01), then a one-byte good frame
    exp_evt(EV_ERR, 2'b10, -1);
    send(8'hAA); send(8'h02); send(8'h01); send(8'h02); send(8'h00);
    idle(2);
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'h5A, 1'b1, 8'd1);
    send(8'hAA); send(8'h01); send(8'h5A); send(8'h5B);
    idle(4);

    // LEN of 0 and LEN above 16, then garbage that must be ignored
    exp_evt(EV_ERR, 2'b01, -1);
    send(8'hAA); send(8'h00);
    exp_evt(EV_ERR, 2'b01, -1);
    send(8'hAA); send(8'h11);
    send(8'h55); send(8'h66);
    idle(4);

    // Backpressure: CHK = 02^A5^5A = FD; a HEADER strobed while draining is dropped
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'hA5, 1'b0, 8'd2);
    exp_beat(8'h5A, 1'b1, 8'd2);
    send(8'hAA); send(8'h02); send(8'hA5); send(8'h5A);
    rx_data_in = 8'hFD;
    rxOK_in    = 1'b1;
    @(posedge clk);
    #1;
    rxOK_in    = 1'b0;
    ready_pat  = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      m_ready_in = ready_pat[i];
      if (i == 2) begin
        rx_data_in = 8'hAA;
        rxOK_in    = 1'b1;
        exp_evt(EV_DROP, 2'b00, -1);
      end
      @(posedge clk);
      #1;
      rxOK_in = 1'b0;
    end
    m_ready_in = 1'b1;
    idle(4);

    // Timeout: error 50 cycles after the last strobe
    send(8'hAA); send(8'h04); send(8'h01);
    exp_evt(EV_ERR, 2'b11, cyc + 50);
    idle(55);

    // Byte on the terminal-count cycle wins; CHK = 04^01^02^03^04 = 00
    send(8'hAA); send(8'h04); send(8'h01);
    idle(49);
    send(8'h02); send(8'h03); send(8'h04);
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'h01, 1'b0, 8'd4);
    exp_beat(8'h02, 1'b0, 8'd4);
    exp_beat(8'h03, 1'b0, 8'd4);
    exp_beat(8'h04, 1'b1, 8'd4);
    send(8'h00);
    idle(6);

    // Reset mid-payload
    send(8'hAA); send(8'h04); send(8'h01); send(8'h02);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_payload", all_outputs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-drain with the consumer stalled
    m_ready_in = 1'b0;
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'hA5, 1'b0, 8'd2);
    exp_beat(8'h5A, 1'b1, 8'd2);
    send(8'hAA); send(8'h02); send(8'hA5); send(8'h5A); send(8'hFD);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_drain", all_outputs(), 0);
    exp_beats.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready_in = 1'b1;

    // Normal frame after reset
    exp_evt(EV_OK, 2'b00, -1);
    exp_beat(8'h11, 1'b0, 8'd3);
    exp_beat(8'h22, 1'b0, 8'd3);
    exp_beat(8'h33, 1'b1, 8'd3);
    send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle(6);

    check("events_left", exp_evts.size(), 0);
    check("beats_left", exp_beats.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
